// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, address shift amounts and size defaults
// for the ext_mem_loader front end.
package loader_pkg;

    // Controller states, in the order a normal load/run/dump session visits them.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_D,
        ST_LOAD_I,
        ST_SETTLE,
        ST_RUN,
        ST_HALT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_OUT
    } state_t;

    // imem is byte addressed (word index << 2); dmem uses 8-byte slots (<< 3).
    localparam int IMEM_SHIFT = 2;
    localparam int DMEM_SHIFT = 3;

    localparam int DEF_IMEM_WORDS = 512;
    localparam int DEF_DMEM_WORDS = 1024;

    // Counter width able to hold 0..words inclusive (dump counts reach DMEM_WORDS).
    function automatic int cnt_width(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/loader_rd_buf.sv
// loader_rd_buf: single-entry holding register for dmem readback words.
// A captured word stays valid and stable on m_data until the consumer takes it.
module loader_rd_buf
    import loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              pop
);

    assign pop = m_valid && m_ready;

    // Capture on load, release on handshake; data is only rewritten by a new load.
    always_ff @(posedge clk) begin
        if (srst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= din;
        end else if (pop) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: preloads dmem then imem from a valid/ready word stream,
// runs the core until a stop pulse, then streams a requested window of dmem
// back out one word at a time.
// Build option: define LOADER_CHECKSUM_EN to build the 32-bit load checksum;
// otherwise checksum is tied to zero.
module ext_mem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = DEF_IMEM_WORDS,
    parameter int DMEM_WORDS = DEF_DMEM_WORDS,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              stop,
    input  logic              dump_req,
    input  logic [10:0]       dump_words,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic [31:0]       checksum
);

    localparam int CNT_W = cnt_width(DMEM_WORDS);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   idx_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   dump_sat;
    logic [ADDR_W-1:0]  addr2_q;
    logic               beat;
    logic               beat_d;
    logic               beat_i;
    logic               start_load;
    logic               rd_load;
    logic               rd_pop;

    // Stream side: words are only taken while loading.
    assign s_ready = (state == ST_LOAD_D) || (state == ST_LOAD_I);
    assign beat    = s_valid && s_ready;
    assign beat_d  = beat && (state == ST_LOAD_D);
    assign beat_i  = beat && (state == ST_LOAD_I);

    assign busy       = !((state == ST_IDLE) || (state == ST_HALT));
    assign start_load = start && ((state == ST_IDLE) || (state == ST_HALT));

    // imem is never read from this side.
    assign ren_ext = 1'b0;

    // Reads are issued straight from RD_REQ; outside it the dmem address
    // keeps showing the last load write address.
    assign ren_ext_2  = (state == ST_RD_REQ);
    assign addr_ext_2 = ren_ext_2 ? (ADDR_W'(idx) << DMEM_SHIFT) : addr2_q;

    // rdata_ext_2 is valid the cycle after the request, i.e. during RD_WAIT.
    assign rd_load = (state == ST_RD_WAIT);

    // Requests larger than dmem are clipped to the whole memory.
    assign dump_sat = (int'(dump_words) > DMEM_WORDS) ? CNT_W'(DMEM_WORDS)
                                                      : CNT_W'(dump_words);

    // State register.
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, index and dump-count decode.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        idx_d      = idx;
        cnt_d      = cnt_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD_D;
                    idx_d      = '0;
                end
            end
            ST_LOAD_D: begin
                if (beat) begin
                    if (idx == CNT_W'(DMEM_WORDS - 1)) begin
                        idx_d      = '0;
                        next_state = ST_LOAD_I;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            ST_LOAD_I: begin
                if (beat) begin
                    if (idx == CNT_W'(IMEM_WORDS - 1)) begin
                        idx_d      = '0;
                        next_state = ST_SETTLE;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                // A new load takes priority over a readback request.
                if (start) begin
                    next_state = ST_LOAD_D;
                    idx_d      = '0;
                end else if (dump_req) begin
                    cnt_d = dump_sat;
                    if (dump_sat != '0) begin
                        idx_d      = '0;
                        next_state = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                next_state = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (rd_pop) begin
                    if (idx == cnt_q - 1'b1) begin
                        next_state = ST_HALT;
                    end else begin
                        idx_d      = idx + 1'b1;
                        next_state = ST_RD_REQ;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Word index and latched dump length.
    always_ff @(posedge clk) begin
        if (srst) begin
            idx   <= '0;
            cnt_q <= '0;
        end else begin
            idx   <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    // Registered write ports: one strobe per accepted beat, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (srst) begin
            wen_ext     <= 1'b0;
            wen_ext_2   <= 1'b0;
            addr_ext    <= '0;
            addr2_q     <= '0;
            wdata_ext   <= '0;
            wdata_ext_2 <= '0;
        end else begin
            wen_ext   <= beat_i;
            wen_ext_2 <= beat_d;
            if (beat_i) begin
                addr_ext  <= ADDR_W'(idx) << IMEM_SHIFT;
                wdata_ext <= s_data;
            end
            if (beat_d) begin
                addr2_q     <= ADDR_W'(idx) << DMEM_SHIFT;
                wdata_ext_2 <= s_data;
            end
        end
    end

    // Core enable follows RUN one cycle late and drops on the stop cycle's edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            cpu_enable <= 1'b0;
        end else begin
            cpu_enable <= (state == ST_RUN) && !stop;
        end
    end

    loader_rd_buf #(
        .DATA_W (DATA_W)
    ) u_rd_buf (
        .clk     (clk),
        .srst    (srst),
        .load    (rd_load),
        .din     (rdata_ext_2),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .pop     (rd_pop)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Modular sum of every accepted load word; restarts with each new load.
    always_ff @(posedge clk) begin
        if (srst || start_load) begin
            sum_q <= '0;
        end else if (beat) begin
            sum_q <= sum_q + 32'(s_data);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: self-checking bench for ext_mem_loader. A behavioural
// dmem/imem model sits on the external ports; expected contents come from
// the words the bench streamed in.
`timescale 1ns/1ps
module tb_ext_mem_loader;

    localparam int IMEM_WORDS = 512;
    localparam int DMEM_WORDS = 1024;
    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 32;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              stop;
    logic              dump_req;
    logic [10:0]       dump_words;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] addr_ext;
    logic              wen_ext;
    logic              ren_ext;
    logic [DATA_W-1:0] wdata_ext;
    logic [ADDR_W-1:0] addr_ext_2;
    logic              wen_ext_2;
    logic              ren_ext_2;
    logic [DATA_W-1:0] wdata_ext_2;
    logic [DATA_W-1:0] rdata_ext_2;
    logic              cpu_enable;
    logic              busy;
    logic [31:0]       checksum;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference memory images as written by the DUT, and expected contents.
    logic [31:0] dmem_img [DMEM_WORDS];
    logic [31:0] imem_img [IMEM_WORDS];
    logic [31:0] exp_d    [DMEM_WORDS];
    logic [31:0] exp_i    [IMEM_WORDS];
    logic [31:0] exp_sum;

    int          wen2_cnt    = 0;
    int          wen_cnt     = 0;
    int          ren2_cnt    = 0;
    int          ren1_cnt    = 0;
    int          mvalid_cnt  = 0;
    int          overlap_cnt = 0;
    int          bad_addr    = 0;
    logic [63:0] last_addr2  = '0;
    logic [63:0] last_addr   = '0;

    ext_mem_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .stop        (stop),
        .dump_req    (dump_req),
        .dump_words  (dump_words),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    // Memory model and port activity monitor; read data appears the cycle
    // after ren_ext_2 and is garbage otherwise.
    always @(posedge clk) begin
        cyc++;
        if (wen_ext_2) begin
            if (addr_ext_2 < 64'h2000 && addr_ext_2[2:0] == 3'd0) dmem_img[addr_ext_2[12:3]] <= wdata_ext_2;
            else bad_addr++;
            wen2_cnt++;
            last_addr2 = addr_ext_2;
        end
        if (wen_ext) begin
            if (addr_ext < 64'h800 && addr_ext[1:0] == 2'd0) imem_img[addr_ext[10:2]] <= wdata_ext;
            else bad_addr++;
            wen_cnt++;
            last_addr = addr_ext;
        end
        if (ren_ext_2) ren2_cnt++;
        if (ren_ext) ren1_cnt++;
        if (m_valid) mvalid_cnt++;
        if ((wen_ext || wen_ext_2) && (ren_ext || ren_ext_2)) overlap_cnt++;
        rdata_ext_2 <= ren_ext_2 ? dmem_img[addr_ext_2[12:3]] : $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a load and streams all words. mode 0: data = index, valid every
    // other cycle; 1: random data and gaps; 2: all ones, valid every cycle.
    task automatic run_load(input int mode, input bit with_dump, output int last_beat);
        int n;
        int guard;
        bit v;
        bit b;
        logic [31:0] w;
        start      = 1'b1;
        dump_req   = with_dump;
        dump_words = 11'd5;
        tick();
        start    = 1'b0;
        dump_req = 1'b0;
        if (with_dump) begin
            checks++;
            if ({s_ready, busy, ren_ext_2} !== 3'b110) begin
                errors++;
                $display("FAIL start_over_dump: {s_ready,busy,ren2}=%b required 110", {s_ready, busy, ren_ext_2});
            end
        end
        n = 0;
        guard = 0;
        exp_sum = '0;
        last_beat = 0;
        while (n < DMEM_WORDS + IMEM_WORDS && guard < 20000) begin
            case (mode)
                0:       v = (guard % 2) == 0;
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            case (mode)
                0:       w = (n < DMEM_WORDS) ? 32'(n) : 32'(n - DMEM_WORDS);
                1:       w = $urandom;
                default: w = 32'h1;
            endcase
            s_valid = v;
            s_data  = w;
            b = v && s_ready;
            tick();
            if (b) begin
                if (n < DMEM_WORDS) exp_d[n] = w;
                else exp_i[n - DMEM_WORDS] = w;
                exp_sum = exp_sum + w;
                last_beat = cyc;
                n++;
            end
            guard++;
        end
        s_valid = 1'b0;
        checks++;
        if (n != DMEM_WORDS + IMEM_WORDS) begin
            errors++;
            $display("FAIL load_beats: accepted %0d required %0d", n, DMEM_WORDS + IMEM_WORDS);
        end
    endtask

    // Checks write counts, final addresses, images, run timing and checksum of a finished load.
    task automatic verify_load(input int w2, input int w1, input int lb, input logic [31:0] exp_ck, input string tag);
        int rise;
        int bad_d;
        int bad_i;
        // Keep offering words after the final beat: none may be accepted.
        s_valid = 1'b1;
        s_data  = 32'hdead_beef;
        rise = -1;
        for (int k = 0; k < 12; k++) begin
            if (cpu_enable && rise < 0) rise = cyc;
            tick();
        end
        s_valid = 1'b0;
        bad_d = 0;
        bad_i = 0;
        for (int i = 0; i < DMEM_WORDS; i++) if (dmem_img[i] !== exp_d[i]) bad_d++;
        for (int i = 0; i < IMEM_WORDS; i++) if (imem_img[i] !== exp_i[i]) bad_i++;
        checks++;
        if (wen2_cnt - w2 != DMEM_WORDS) begin
            errors++;
            $display("FAIL %s dmem_writes: got %0d required %0d", tag, wen2_cnt - w2, DMEM_WORDS);
        end
        checks++;
        if (last_addr2 !== 64'h1FF8) begin
            errors++;
            $display("FAIL %s dmem_last_addr: got %h required 1ff8", tag, last_addr2);
        end
        checks++;
        if (wen_cnt - w1 != IMEM_WORDS) begin
            errors++;
            $display("FAIL %s imem_writes: got %0d required %0d", tag, wen_cnt - w1, IMEM_WORDS);
        end
        checks++;
        if (last_addr !== 64'h7FC) begin
            errors++;
            $display("FAIL %s imem_last_addr: got %h required 7fc", tag, last_addr);
        end
        checks++;
        if (bad_d != 0) begin
            errors++;
            $display("FAIL %s dmem_image: %0d wrong words, required 0", tag, bad_d);
        end
        checks++;
        if (bad_i != 0) begin
            errors++;
            $display("FAIL %s imem_image: %0d wrong words, required 0", tag, bad_i);
        end
        checks++;
        if (rise < 0 || rise - lb != 2) begin
            errors++;
            $display("FAIL %s cpu_enable_delay: rose at %0d cycles after last beat, required 2", tag, rise - lb);
        end
        checks++;
        if ({busy, cpu_enable} !== 2'b11) begin
            errors++;
            $display("FAIL %s run_state: {busy,cpu_enable}=%b required 11", tag, {busy, cpu_enable});
        end
        checks++;
        if (checksum !== exp_ck) begin
            errors++;
            $display("FAIL %s checksum: got %h required %h", tag, checksum, exp_ck);
        end
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({cpu_enable, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s stop_halt: {cpu_enable,busy}=%b required 00", tag, {cpu_enable, busy});
        end
    endtask

    // Requests a readback from HALT and checks every word against the streamed data.
    task automatic run_dump(input int req, input bit stall, input string tag);
        int exp_n;
        int got;
        int guard;
        int r2;
        int prev_hs;
        int bad_gap;
        int stall_bad;
        bit stalled_word;
        logic [31:0] held;
        exp_n = (req > DMEM_WORDS) ? DMEM_WORDS : req;
        r2 = ren2_cnt;
        got = 0;
        guard = 0;
        prev_hs = -1;
        bad_gap = 0;
        stall_bad = 0;
        dump_words = 11'(req);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        while (got < exp_n && guard < 4 * exp_n + 60) begin
            if (m_valid) begin
                stalled_word = stall && (got == 10);
                if (stalled_word) begin
                    held = m_data;
                    m_ready = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        tick();
                        if (m_valid !== 1'b1 || m_data !== held) stall_bad++;
                    end
                end
                checks++;
                if (m_data !== exp_d[got]) begin
                    errors++;
                    $display("FAIL %s dump_word[%0d]: got %h required %h", tag, got, m_data, exp_d[got]);
                end
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
                if (prev_hs >= 0 && !stalled_word && cyc - prev_hs != 3) bad_gap++;
                prev_hs = cyc;
                got++;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
                m_ready = 1'b0;
            end
            guard++;
        end
        checks++;
        if (got != exp_n) begin
            errors++;
            $display("FAIL %s dump_count: got %0d required %0d", tag, got, exp_n);
        end
        checks++;
        if (ren2_cnt - r2 != exp_n) begin
            errors++;
            $display("FAIL %s dump_reads: got %0d required %0d", tag, ren2_cnt - r2, exp_n);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL %s dump_throughput: %0d gaps not 3 cycles, required 0", tag, bad_gap);
        end
        if (stall) begin
            checks++;
            if (stall_bad != 0) begin
                errors++;
                $display("FAIL %s dump_stall_hold: %0d unstable cycles, required 0", tag, stall_bad);
            end
        end
        checks++;
        if ({busy, m_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s dump_back_to_halt: {busy,m_valid}=%b required 00", tag, {busy, m_valid});
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s_ready, busy, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2, m_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000000",
                     {s_ready, busy, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2, m_valid});
        end
        checks++;
        if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: addr=%h addr2=%h m_data=%h required 0", addr_ext, addr_ext_2, m_data);
        end
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_checksum: got %h required 0", checksum);
        end
        srst = 1'b0;
        // stop and dump_req are ignored in IDLE.
        stop = 1'b1;
        dump_req = 1'b1;
        dump_words = 11'd3;
        tick();
        stop = 1'b0;
        dump_req = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, ren_ext_2, m_valid, s_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignores: {busy,ren2,m_valid,s_ready}=%b required 0000", {busy, ren_ext_2, m_valid, s_ready});
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        int guard;
        bit b;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        guard = 0;
        while (n < 5 && guard < 50) begin
            s_valid = 1'b1;
            s_data = $urandom;
            b = s_ready;
            tick();
            if (b) n++;
            guard++;
        end
        checks++;
        if ({wen_ext_2, addr_ext_2} !== {1'b1, 64'h20}) begin
            errors++;
            $display("FAIL fifth_beat_write: wen2=%b addr2=%h required 1/20", wen_ext_2, addr_ext_2);
        end
        srst = 1'b1;
        tick();
        checks++;
        if ({wen_ext, wen_ext_2, ren_ext_2, s_ready, busy, cpu_enable} !== 6'b0) begin
            errors++;
            $display("FAIL midload_reset: {wen,wen2,ren2,s_ready,busy,cpu_en}=%b required 000000",
                     {wen_ext, wen_ext_2, ren_ext_2, s_ready, busy, cpu_enable});
        end
        srst = 1'b0;
        s_valid = 1'b0;
        tick();
        // Valid is already high at the start edge; only the next edge accepts.
        start = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h1234_5678;
        tick();
        start = 1'b0;
        checks++;
        if ({wen_ext_2, s_ready} !== 2'b01) begin
            errors++;
            $display("FAIL restart_no_early_write: {wen2,s_ready}=%b required 01", {wen_ext_2, s_ready});
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if ({wen_ext_2, addr_ext_2, wdata_ext_2} !== {1'b1, 64'h0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL restart_index0: wen2=%b addr2=%h data=%h required 1/0/12345678",
                     wen_ext_2, addr_ext_2, wdata_ext_2);
        end
        tick();
        checks++;
        if ({wen_ext_2, addr_ext_2} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL idle_beat_no_strobe: wen2=%b addr2=%h required 0/0", wen_ext_2, addr_ext_2);
        end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        int w2;
        int w1;
        int lb;
        w2 = wen2_cnt;
        w1 = wen_cnt;
        run_load(0, 1'b0, lb);
        verify_load(w2, w1, lb, CK_EN ? exp_sum : 32'h0, "index_load");
    endtask

    task automatic test_stop_dump();
        do_stop("first_stop");
        run_dump(47, 1'b1, "dump47");
    endtask

    task automatic test_dump_zero();
        int r2;
        int mv;
        r2 = ren2_cnt;
        mv = mvalid_cnt;
        dump_words = 11'd0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (ren2_cnt - r2 != 0 || mvalid_cnt - mv != 0) begin
            errors++;
            $display("FAIL dump_zero: reads=%0d valids=%0d required 0/0", ren2_cnt - r2, mvalid_cnt - mv);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_zero_halt: busy=%b required 0", busy);
        end
    endtask

    task automatic test_start_and_dump();
        int w2;
        int w1;
        int r2;
        int lb;
        w2 = wen2_cnt;
        w1 = wen_cnt;
        r2 = ren2_cnt;
        run_load(2, 1'b1, lb);
        verify_load(w2, w1, lb, CK_EN ? 32'h600 : 32'h0, "ones_load");
        checks++;
        if (ren2_cnt - r2 != 0) begin
            errors++;
            $display("FAIL start_wins_no_read: reads=%0d required 0", ren2_cnt - r2);
        end
        do_stop("ones_stop");
    endtask

    task automatic test_random_load();
        int w2;
        int w1;
        int lb;
        w2 = wen2_cnt;
        w1 = wen_cnt;
        start = 1'b0;
        run_load(1, 1'b0, lb);
        verify_load(w2, w1, lb, CK_EN ? exp_sum : 32'h0, "random_load");
        do_stop("random_stop");
        for (int k = 0; k < 3; k++) run_dump(int'($urandom_range(1, 80)), 1'b0, "dump_rand");
        run_dump(2000, 1'b0, "dump_saturate");
        run_dump(DMEM_WORDS, 1'b1, "dump_full");
    endtask

    task automatic test_invariants();
        checks++;
        if (ren1_cnt != 0) begin
            errors++;
            $display("FAIL ren_ext_stuck: asserted %0d cycles required 0", ren1_cnt);
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL strobe_overlap: %0d cycles with write and read together, required 0", overlap_cnt);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL write_addr_range: %0d bad write addresses, required 0", bad_addr);
        end
    endtask

    initial begin
        srst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        stop = 1'b0;
        dump_req = 1'b0;
        dump_words = '0;
        m_ready = 1'b0;
        test_reset();
        test_reset_mid_load();
        test_full_load();
        test_stop_dump();
        test_dump_zero();
        test_start_and_dump();
        test_random_load();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
- Host-side front end that drives the CPU's two external memory ports.
- Preloads dmem (port 2) and then imem (port 1) from a valid/ready word stream, then releases `cpu_enable`.
- On a stop indication it halts the core and streams a requested window of dmem back out for result checking.
- Replaces the ad-hoc bench load/dump tasks with synthesizable logic sitting directly upstream of the `cpu` external ports.

Parameters:
- IMEM_WORDS, 512: number of 32-bit words written to imem.
- DMEM_WORDS, 1024: number of words written to dmem.
- ADDR_W, 64: external address width.
- DATA_W, 32: external data width.

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a load sequence from IDLE
- s_valid  in  1  input stream word valid
- s_ready  out  1  loader accepts a word
- s_data  in  DATA_W  input stream word
- stop  in  1  pulse from the CPU STOP-opcode decode; halts the core
- dump_req  in  1  pulse; start a dmem readback (accepted in HALT only)
- dump_words  in  11  number of dmem words to read back, 0..DMEM_WORDS
- m_valid  out  1  readback word valid
- m_ready  in  1  consumer accepts a readback word
- m_data  out  DATA_W  readback word
- addr_ext  out  ADDR_W  imem address (byte address, word index << 2)
- wen_ext  out  1  imem write strobe
- ren_ext  out  1  imem read strobe (always 0)
- wdata_ext  out  DATA_W  imem write data
- addr_ext_2  out  ADDR_W  dmem address (word index << 3)
- wen_ext_2  out  1  dmem write strobe
- ren_ext_2  out  1  dmem read strobe
- wdata_ext_2  out  DATA_W  dmem write data
- rdata_ext_2  in  DATA_W  dmem read data; valid the cycle after ren_ext_2
- cpu_enable  out  1  core run enable
- busy  out  1  high in every state except IDLE and HALT
- checksum  out  32  load checksum (see Optional Feature)

Behaviour:
- Reset (srst sampled at a rising edge): state IDLE; all outputs 0; index counter 0; any load or dump in progress is abandoned.
- States: IDLE, LOAD_D, LOAD_I, SETTLE, RUN, HALT, RD_REQ, RD_WAIT, RD_OUT.
- IDLE: on `start` go to LOAD_D. `stop` and `dump_req` are ignored.
- LOAD_D / LOAD_I:
  - `s_ready` = 1 in these states only.
  - Beat accepted when `s_valid && s_ready`.
  - The cycle after a beat: registered `wen_ext_2` (LOAD_D) or `wen_ext` (LOAD_I) = 1 for exactly one cycle, with address = idx << 3 (dmem) or idx << 2 (imem), zero-extended, and wdata = beat.
  - No beat in a cycle: no write strobe next cycle; address and data hold.
  - On the beat with idx == DMEM_WORDS-1: idx clears to 0 and the state moves to LOAD_I.
  - On the beat with idx == IMEM_WORDS-1: the state moves to SETTLE.
  - `s_ready` drops in the same cycle as the final beat of LOAD_I, so no extra word is accepted.
- SETTLE: one cycle; lets the final write complete. Then go to RUN.
- RUN: `cpu_enable` = 1, registered, so it rises one cycle after entering RUN. On `stop`, `cpu_enable` = 0 next cycle and the state moves to HALT.
- HALT:
  - On `dump_req`, latch `dump_words`.
  - Latched value 0: stay in HALT and emit nothing.
  - Otherwise idx = 0 and go to RD_REQ.
  - On `start`, begin a new load (LOAD_D). If both are asserted, `start` wins.
- Readback, one outstanding read at a time:
  - RD_REQ: `ren_ext_2` = 1, `addr_ext_2` = idx << 3; then RD_WAIT.
  - RD_WAIT: capture `rdata_ext_2` into `m_data`, `m_valid` = 1; then RD_OUT.
  - RD_OUT: hold `m_valid` and `m_data` stable until `m_ready`. On the handshake, if idx == latched count - 1 go to HALT, else increment idx and go to RD_REQ.
  - Throughput is one word per 3 cycles when `m_ready` is held high.
- `ren_ext` is always 0. Write and read strobes are never asserted together.
- `dump_words` above DMEM_WORDS saturates to DMEM_WORDS.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - `checksum` is a 32-bit modular sum of every accepted load word, dmem and imem combined.
  - Cleared on `srst` and on `start`.
  - Updated the cycle after each beat; stable from SETTLE onward.
- Not defined: `checksum` is tied to 0 and no accumulator is built.

Decomposition:
- Package `loader_pkg`: state enum, IMEM/DMEM shift constants (2 and 3), default size constants, count width = $clog2(DMEM_WORDS)+1.
- One natural sub-module, `loader_rd_buf`: the single-entry m_valid/m_data holding register with ready handshake.

Test Plan:
- Reset mid-load: assert srst after 5 dmem beats -> all strobes 0, `s_ready` 0, state IDLE; `start` then reloads from dmem index 0.
- Full load with gapped valid (valid toggling every other cycle, data = index):
  - `wen_ext_2` asserted exactly 1024 times, last at `addr_ext_2` = 0x1FF8.
  - `wen_ext` asserted 512 times, last at `addr_ext` = 0x7FC.
  - `cpu_enable` rises 2 cycles after the last beat.
- Stop then dump with `dump_words` = 47 and `m_ready` stalled for 4 cycles on word 10 -> 47 outputs in order; `m_data` holds during the stall; the state returns to HALT.
- dump_req with `dump_words` = 0 -> no `ren_ext_2` and no `m_valid`; the state stays HALT.
- Checksum, with LOADER_CHECKSUM_EN: load words all 0x00000001 -> `checksum` = 0x600. Without the macro -> `checksum` = 0.
- `start` and `dump_req` together in HALT -> a new load begins and no read is issued.
